// File: rtl/synaptic_current_gen_if.sv
// Interface bundling the spike-frame handshake, the weight write port and the
// current output of synaptic_current_gen.
//   master : upstream driver (spike source / weight programmer / neuron side)
//   slave  : synaptic_current_gen itself
// Signals:
//   spike_in[N_SYN]   presynaptic spike frame, bit k = synapse k fired
//   spike_valid       spike_in holds a frame
//   spike_ready       generator can accept a frame
//   w_we/w_addr/w_data weight write port (signed W_WIDTH data)
//   input_current     signed 16-bit saturated synaptic current
//   current_valid     one-cycle pulse when input_current updates
//   saturated         last update was clamped
interface synaptic_current_gen_if #(
  parameter int N_SYN   = 8,
  parameter int W_WIDTH = 8
);
  localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1;

  logic [N_SYN-1:0]          spike_in;
  logic                      spike_valid;
  logic                      spike_ready;
  logic                      w_we;
  logic [AW-1:0]             w_addr;
  logic signed [W_WIDTH-1:0] w_data;
  logic signed [15:0]        input_current;
  logic                      current_valid;
  logic                      saturated;

  modport master (
    output spike_in, spike_valid, w_we, w_addr, w_data,
    input  spike_ready, input_current, current_valid, saturated
  );

  modport slave (
    input  spike_in, spike_valid, w_we, w_addr, w_data,
    output spike_ready, input_current, current_valid, saturated
  );
endinterface

// File: rtl/synaptic_current_gen.sv
// Synaptic current generator feeding the Izhikevich neuron.
// Each accepted spike frame applies one exponential-decay step to the current
// state, then serially adds the weight of every active synapse (one synapse
// per cycle), clamps to [I_MIN, I_MAX] and pulses current_valid.
// Ports:
//   clk     : clock, rising-edge
//   reset_n : asynchronous active-low reset
//   bus     : synaptic_current_gen_if.slave (frame handshake, weight port,
//             current output)
module synaptic_current_gen #(
  parameter int                 N_SYN       = 8,
  parameter int                 W_WIDTH     = 8,
  parameter int                 DECAY_SHIFT = 3,
  parameter logic signed [15:0] I_MAX       = 16'sd1000,
  parameter logic signed [15:0] I_MIN       = -16'sd1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  synaptic_current_gen_if.slave   bus
);
  localparam int                 AW       = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam logic signed [23:0] ACC_MAX  = 24'(I_MAX);
  localparam logic signed [23:0] ACC_MIN  = 24'(I_MIN);
  localparam logic [AW-1:0]      IDX_LAST = AW'(N_SYN - 1);

  typedef enum logic [1:0] {IDLE, DECAY, ACCUM, OUT} state_t;

  state_t                    state, state_nxt;
  logic [N_SYN-1:0]          frame;
  logic signed [23:0]        acc;
  logic [AW-1:0]             idx;
  logic signed [W_WIDTH-1:0] weight [N_SYN];
  logic signed [15:0]        cur;
  logic                      cur_vld;
  logic                      sat;
  logic                      accept;
  logic signed [23:0]        acc_dec;
  logic signed [23:0]        w_ext;

  assign bus.spike_ready   = (state == IDLE);
  assign bus.input_current = cur;
  assign bus.current_valid = cur_vld;
  assign bus.saturated     = sat;

  assign accept  = bus.spike_valid && (state == IDLE);
  // Arithmetic shift rounds toward -inf, so -1 decays to 0.
  assign acc_dec = acc - (acc >>> DECAY_SHIFT);
  assign w_ext   = 24'(weight[idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DECAY;
      DECAY:   state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_LAST) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight file: writable in any state; an ACCUM read in the same cycle as
  // a write to that index still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_SYN; k++) weight[k] <= '0;
    end else if (bus.w_we && (int'(bus.w_addr) < N_SYN)) begin
      weight[bus.w_addr] <= bus.w_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame   <= '0;
      acc     <= '0;
      idx     <= '0;
      cur     <= '0;
      cur_vld <= 1'b0;
      sat     <= 1'b0;
    end else begin
      cur_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            frame <= bus.spike_in;
            acc   <= 24'(cur);
          end
        end
        DECAY: begin
          acc <= acc_dec;
          idx <= '0;
        end
        ACCUM: begin
          if (frame[idx]) acc <= acc + w_ext;
          idx <= idx + 1'b1;
        end
        OUT: begin
          cur_vld <= 1'b1;
          if (acc > ACC_MAX) begin
            cur <= I_MAX;
            acc <= ACC_MAX;
            sat <= 1'b1;
          end else if (acc < ACC_MIN) begin
            cur <= I_MIN;
            acc <= ACC_MIN;
            sat <= 1'b1;
          end else begin
            cur <= acc[15:0];
            sat <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_synaptic_current_gen.sv
// Self-checking bench for synaptic_current_gen. Expected currents come from a
// behavioural model evaluated when a frame is accepted and are queued; the
// monitor pops and compares them at each current_valid pulse, along with the
// accept-to-pulse latency.
module tb_synaptic_current_gen;
  localparam int N     = 8;
  localparam int SHIFT = 3;
  localparam int IMAX  = 1000;
  localparam int IMIN  = -1000;

  typedef struct {
    int   cur;
    logic sat;
  } exp_t;

  logic clk;
  logic reset_n;

  synaptic_current_gen_if #(.N_SYN(N), .W_WIDTH(8)) bus ();

  synaptic_current_gen #(
    .N_SYN(N), .W_WIDTH(8), .DECAY_SHIFT(SHIFT),
    .I_MAX(16'sd1000), .I_MIN(-16'sd1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_pulses = 0;
  logic prev_cv  = 1'b0;
  int   model_cur = 0;
  int   model_w [N];
  exp_t exp_q [$];
  int   acc_q [$];
  int   acc_log [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: model evaluation on accept, scoreboard pop on pulse.
  always @(negedge clk) begin
    if (reset_n && bus.current_valid) begin
      n_pulses++;
      chk("pulse_one_cycle", prev_cv, 0);
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("input_current", bus.input_current, e.cur);
        chk("saturated", bus.saturated, e.sat);
        chk("latency", cyc - a, N + 2);
      end
    end
    prev_cv = bus.current_valid;
    if (reset_n && bus.spike_valid && bus.spike_ready) begin
      exp_t e;
      int   c;
      c = model_cur;
      c = c - (c >>> SHIFT);
      for (int k = 0; k < N; k++) if (bus.spike_in[k]) c += model_w[k];
      e.sat = (c > IMAX) || (c < IMIN);
      if (c > IMAX) c = IMAX;
      if (c < IMIN) c = IMIN;
      e.cur = c;
      model_cur = c;
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      acc_log.push_back(cyc + 1);
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.spike_valid = 1'b0;
    bus.w_we = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_cur = 0;
    for (int k = 0; k < N; k++) model_w[k] = 0;
    #1;
    chk("rst_current", bus.input_current, 0);
    chk("rst_valid", bus.current_valid, 0);
    chk("rst_sat", bus.saturated, 0);
    chk("rst_ready", bus.spike_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wset(input int k, input int v);
    @(posedge clk);
    #1;
    bus.w_we   = 1'b1;
    bus.w_addr = 3'(k);
    bus.w_data = 8'(v);
    model_w[k] = v;
    @(posedge clk);
    #1 bus.w_we = 1'b0;
  endtask

  task automatic wall(input int v);
    for (int k = 0; k < N; k++) wset(k, v);
  endtask

  // Presents a frame, waits (bounded) for acceptance, then scrambles spike_in
  // to confirm the DUT latched it. Returns just after the accepting edge.
  task automatic send_frame(input logic [N-1:0] f);
    logic got;
    @(posedge clk);
    #1;
    bus.spike_in    = f;
    bus.spike_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.spike_ready) got = 1'b1;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.spike_valid = 1'b0;
    bus.spike_in    = ~f;
    chk("ready_low_busy", bus.spike_ready, 0);
  endtask

  task automatic run(input logic [N-1:0] f);
    send_frame(f);
    repeat (N + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b1;
    bus.spike_in    = '0;
    bus.spike_valid = 1'b0;
    bus.w_we        = 1'b0;
    bus.w_addr      = '0;
    bus.w_data      = '0;
    @(posedge clk);
    #3 do_reset();

    // Full frame with weights 10, then decay-only frames: 80, 70, 62.
    wall(10);
    run(8'hFF);
    run(8'h00);
    run(8'h00);
    chk("hold_between_pulses", bus.input_current, 62);

    // Positive and negative saturation, then decay out of saturation.
    @(posedge clk); #3 do_reset();
    wall(127);
    run(8'hFF);
    @(posedge clk); #3 do_reset();
    wall(-128);
    run(8'hFF);
    wall(0);
    chk("sat_held", bus.saturated, 1);
    run(8'h00);

    // Sparse frame with mixed-sign weights: -2.
    @(posedge clk); #3 do_reset();
    for (int k = 0; k < N; k++) wset(k, k - 4);
    run(8'b1010_0101);

    // Negative decay: -100 -> -87; and -1 -> 0.
    @(posedge clk); #3 do_reset();
    wset(0, -100);
    run(8'h01);
    run(8'h00);
    @(posedge clk); #3 do_reset();
    wset(0, -1);
    run(8'h01);
    run(8'h00);

    // Weight write landing on the ACCUM cycle that reads index 3.
    @(posedge clk); #3 do_reset();
    wall(10);
    send_frame(8'h08);
    repeat (4) @(posedge clk);
    #1;
    bus.w_we   = 1'b1;
    bus.w_addr = 3'd3;
    bus.w_data = 8'sd50;
    @(posedge clk);
    #1 bus.w_we = 1'b0;
    model_w[3] = 50;
    repeat (N + 3) @(posedge clk);
    #1;
    run(8'h08);

    // Continuous spike_valid: accepts spaced N+3 apart.
    acc_log.delete();
    bus.spike_in    = 8'h01;
    bus.spike_valid = 1'b1;
    repeat (40) @(posedge clk);
    begin
      logic got;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (bus.spike_ready) got = 1'b1;
      end
      chk("accept_timeout_cont", got, 1);
    end
    @(posedge clk);
    #1 bus.spike_valid = 1'b0;
    chk("accepts_seen", acc_log.size() >= 4, 1);
    for (int i = 1; i < acc_log.size(); i++)
      chk("accept_spacing", acc_log[i] - acc_log[i-1], N + 3);

    // Reset mid-ACCUM: outputs clear at once, frame aborted without pulse.
    repeat (4) @(posedge clk);
    #3;
    chk("pre_abort_nonzero", bus.input_current != 0, 1);
    begin
      int p;
      do_reset();
      p = n_pulses;
      repeat (20) @(posedge clk);
      #1;
      chk("no_pulse_after_abort", n_pulses, p);
      chk("ready_after_reset", bus.spike_ready, 1);
      chk("current_after_reset", bus.input_current, 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/synaptic_current_gen.md
Name: synaptic_current_gen

Overview:
- Upstream stage of the Izhikevich neuron. Converts a vector of presynaptic spikes into the signed 16-bit input_current that the neuron consumes.
- Keeps a decaying synaptic current state. Each accepted spike frame applies one exponential-decay step, then serially adds the programmable weight of every active synapse.
- Saturates the result and presents it with a one-cycle valid pulse.
- Synapse weights are held in a small register file written through a simple write port.

Parameters:
N_SYN, 8, number of presynaptic inputs (2..32)
W_WIDTH, 8, signed weight width in bits
DECAY_SHIFT, 3, decay factor: I <= I - (I >>> DECAY_SHIFT)
I_MAX, 16'sd1000, positive saturation limit of the current
I_MIN, -16'sd1000, negative saturation limit of the current

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
spike_in  input  N_SYN  presynaptic spike frame, bit k = synapse k fired
spike_valid  input  1  spike_in holds a frame
spike_ready  output  1  block can accept a frame (high only in IDLE)
w_we  input  1  weight write enable
w_addr  input  $clog2(N_SYN)  weight index
w_data  input  W_WIDTH  signed weight value
input_current  output  16  signed saturated synaptic current, drives neuron input_current
current_valid  output  1  one-cycle pulse when input_current is updated
saturated  output  1  last update was clamped, held until the next update

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting reset_n=0 immediately forces:
  - state IDLE; all weights 0; internal accumulator 0
  - input_current=0, current_valid=0, saturated=0, spike_ready=1
- Reset mid-frame aborts the frame with no output pulse.
- Handshake: a frame is accepted on the rising edge where spike_valid && spike_ready. spike_in is latched at that edge; later changes are ignored. While not in IDLE, spike_ready=0 and spike_valid is ignored.
- FSM:
  - IDLE: on accept, latch the frame, load the accumulator from input_current (sign-extended to 24 bits), go to DECAY.
  - DECAY (1 cycle): acc <= acc - (acc >>> DECAY_SHIFT), arithmetic shift. Clear idx. Go to ACCUM.
  - ACCUM (N_SYN cycles): if frame[idx], acc <= acc + sign_extend(weight[idx]). idx++. After idx=N_SYN-1, go to OUT.
  - OUT (1 cycle): clamp acc to [I_MIN, I_MAX] into input_current. Set saturated if clamped, else clear it. Pulse current_valid=1. Clamp acc too. Return to IDLE.
- Latency: input_current and current_valid update on the (N_SYN+2)th rising edge after the accepting edge.
  - The next frame can be accepted on the edge after current_valid is high.
  - Throughput: one frame per N_SYN+3 cycles.
- Arithmetic:
  - 24-bit signed accumulator; no internal overflow is possible within range limits.
  - The decay of a negative value rounds toward -inf on the shift (e.g. -100 -> -87).
  - 0 decays to 0. Values with |I| < 2^DECAY_SHIFT whose shift is 0 are unchanged, except negatives: -1 >>> 3 = -1, so -1 -> 0.
- Weights:
  - w_we writes weight[w_addr] <= w_data at the rising edge, in any state.
  - A write takes effect from the next cycle. An ACCUM read of the same index in the write cycle uses the old value.
  - w_addr >= N_SYN is ignored.
- Empty frame (spike_in=0) still runs the full sequence: decay only, with a current_valid pulse.
- input_current holds its value between pulses. current_valid is never asserted outside OUT.

Test Plan:
1. Reset then release, all weights 10, input_current 0, frame 8'hFF accepted -> current_valid on the 10th edge after accept, input_current=80, saturated=0.
2. From 80, frame 8'h00 -> 70 (80-10). Next 8'h00 -> 62 (70-8). Checks decay-only frames and the 1-cycle valid pulse.
3. Weights all 127, frame 8'hFF from 0 -> input_current=1000, saturated=1. Weights all -128 from 0 -> -1000, saturated=1. Then weights 0, frame 8'h00 from -1000 -> -875, saturated=0.
4. Sparse frame 8'b1010_0101, weights w[k]=k-4, from 0 -> (-4)+(-2)+1+3 = -2. Also check negative decay: state -100, frame 0 -> -87.
5. Write weight[3]=50 during the ACCUM cycle that reads idx 3, frame 8'h08, start 0 -> uses the old weight (10) -> 10. Next frame 8'h08 -> 9+50 = 59. Confirms write timing.
6. spike_valid held high continuously -> accepts spaced exactly N_SYN+3 cycles apart, spike_ready low in between. Drive reset_n low mid-ACCUM -> outputs 0 immediately, no current_valid pulse, spike_ready=1 after release.
